// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared state, opcode-class, exception-cause and PC-mux encodings
package pc_ctrl_pkg;
  typedef enum logic [2:0] {RESET_S, FETCH, DECODE, EXEC, EXC_SAVE, EXC_JUMP} state_t;
  localparam logic [2:0] OP_ALU = 3'd0;
  localparam logic [2:0] OP_BEQ = 3'd1;
  localparam logic [2:0] OP_BNE = 3'd2;
  localparam logic [2:0] OP_J   = 3'd3;
  localparam logic [2:0] OP_JAL = 3'd4;
  localparam logic [2:0] OP_JR  = 3'd5;
  localparam logic [2:0] OP_RTE = 3'd6;
  localparam logic [2:0] OP_INV = 3'd7;
  localparam logic [1:0] EXC_INV  = 2'd0;
  localparam logic [1:0] EXC_OVF  = 2'd1;
  localparam logic [1:0] EXC_DIV0 = 2'd2;
  localparam logic [1:0] EXC_BUS  = 2'd3;
  localparam logic [1:0] PCSEL_SEQ    = 2'd0;
  localparam logic [1:0] PCSEL_ALUOUT = 2'd1;
  localparam logic [1:0] PCSEL_JUMP   = 2'd2;
  localparam logic [1:0] PCSEL_EXC    = 2'd3;
endpackage

// File: rtl/pc_ctrl_timer.sv
// pc_ctrl_timer: saturating fetch-wait counter with clear and terminal-count flag
module pc_ctrl_timer #(
  parameter int MAX = 15,
  parameter int TW  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);
  logic [TW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (reset || i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_tc = r_cnt == TW'(MAX - 1);
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: multicycle sequencer driving the PC source mux, PC/IR/EPC strobes and exception entry/return
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op_kind,
  input  logic       alu_zero,
  input  logic       exc_ovf,
  input  logic       exc_div0,
  input  logic       stall,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       ir_write,
  output logic [1:0] pc_sel,
  output logic       pc_write,
  output logic       epc_write,
  output logic       vec_epc,
  output logic [1:0] exc_code,
  output logic       exc_en
);
  state_t     r_state, w_next;
  logic [1:0] r_exc_code, w_cause;
  logic       r_exc_en, w_take, w_rte, w_tc, w_wait;
  assign w_wait = r_state == FETCH && !mem_ready;
  pc_ctrl_timer #(.MAX(MEM_TIMEOUT), .TW(TW)) u_timer (
    .clk(clk), .reset(reset), .i_clr(!w_wait), .i_inc(w_wait), .o_tc(w_tc)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_state    <= RESET_S;
      r_exc_code <= EXC_INV;
      r_exc_en   <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_take) r_exc_code <= w_cause;
      if (r_state == EXC_SAVE) r_exc_en <= 1'b0;
      else if (w_rte) r_exc_en <= 1'b1;
    end
  always_comb begin
    w_next    = r_state;
    mem_rd    = 1'b0;
    ir_write  = 1'b0;
    pc_sel    = PCSEL_SEQ;
    pc_write  = 1'b0;
    epc_write = 1'b0;
    vec_epc   = 1'b0;
    w_take    = 1'b0;
    w_cause   = EXC_INV;
    w_rte     = 1'b0;
    case (r_state)
      RESET_S: w_next = FETCH;
      FETCH: begin
        mem_rd   = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        w_take   = w_wait && w_tc && r_exc_en;
        w_cause  = EXC_BUS;
        w_next   = mem_ready ? DECODE : w_take ? EXC_SAVE : FETCH;
      end
      DECODE: begin
        w_take = op_kind == OP_INV && r_exc_en;
        w_next = w_take ? EXC_SAVE : op_kind == OP_INV ? FETCH : EXEC;
      end
      EXEC: if (!stall) begin
        // a pending arithmetic exception suppresses the commit in the same cycle
        w_take  = op_kind == OP_ALU && (exc_ovf || exc_div0) && r_exc_en;
        w_cause = exc_ovf ? EXC_OVF : EXC_DIV0;
        w_next  = w_take ? EXC_SAVE : FETCH;
        w_rte   = !w_take && op_kind == OP_RTE;
        vec_epc = w_rte;
        pc_sel  = w_take ? PCSEL_SEQ :
                  (op_kind == OP_J || op_kind == OP_JAL) ? PCSEL_JUMP :
                  op_kind == OP_RTE ? PCSEL_EXC :
                  (op_kind == OP_BEQ || op_kind == OP_BNE || op_kind == OP_JR) ? PCSEL_ALUOUT : PCSEL_SEQ;
        pc_write = w_take ? 1'b0 :
                   op_kind == OP_BEQ ? alu_zero :
                   op_kind == OP_BNE ? !alu_zero : op_kind != OP_ALU;
      end
      EXC_SAVE: begin
        epc_write = 1'b1;
        w_next    = EXC_JUMP;
      end
      EXC_JUMP: begin
        pc_sel   = PCSEL_EXC;
        pc_write = 1'b1;
        w_next   = FETCH;
      end
      default: w_next = RESET_S;
    endcase
  end
  assign exc_code = r_exc_code;
  assign exc_en   = r_exc_en;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: instruction-level reference model producing expected per-cycle output traces
module tb_pc_ctrl;
  localparam int MT = 15;
  localparam logic [6:0] S_IDLE = 7'b0000000;
  localparam logic [6:0] S_FWAIT = 7'b1000000;
  localparam logic [6:0] S_FOK = 7'b1100100;
  localparam logic [6:0] S_SAVE = 7'b0000010;
  localparam logic [6:0] S_JUMP = 7'b0011100;
  localparam logic [6:0] S_RTE = 7'b0011101;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] op_kind = '0;
  logic alu_zero = 0, exc_ovf = 0, exc_div0 = 0, stall = 0, mem_ready = 0;
  logic mem_rd, ir_write, pc_write, epc_write, vec_epc, exc_en;
  logic [1:0] pc_sel, exc_code;
  pc_ctrl #(.MEM_TIMEOUT(MT), .TW(8)) dut (
    .clk(clk), .reset(reset), .op_kind(op_kind), .alu_zero(alu_zero), .exc_ovf(exc_ovf),
    .exc_div0(exc_div0), .stall(stall), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .ir_write(ir_write), .pc_sel(pc_sel), .pc_write(pc_write), .epc_write(epc_write),
    .vec_epc(vec_epc), .exc_code(exc_code), .exc_en(exc_en)
  );
  always #5 clk = ~clk;
  int n_run = 0, n_fail = 0;
  bit m_en = 1'b1;
  logic [1:0] m_code = 2'd0;
  logic [9:0] q_obs[$], q_exp[$];
  wire [9:0] w_obs = {mem_rd, ir_write, pc_sel, pc_write, epc_write, vec_epc, exc_code, exc_en};
  // strobe order: mem_rd ir_write pc_sel[1:0] pc_write epc_write vec_epc
  task automatic cyc(input logic [6:0] s, input logic rst, rdy, st, input logic [2:0] op,
                     input logic z, ov, dz);
    @(negedge clk);
    reset = rst; mem_ready = rdy; stall = st; op_kind = op;
    alu_zero = z; exc_ovf = ov; exc_div0 = dz;
    #1;
    q_obs.push_back(w_obs);
    q_exp.push_back({s, m_code, m_en});
  endtask
  task automatic junk(input logic [6:0] s, input logic rst, rdy, st);
    cyc(s, rst, rdy, st, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask
  task automatic exc_seq(input logic [1:0] code, input bit rst_save);
    m_code = code;
    junk(S_SAVE, rst_save, 1'($urandom), 1'($urandom));
    if (rst_save) begin
      m_code = 2'd0;
      m_en = 1'b1;
      junk(S_IDLE, 1'b1, 1'($urandom), 1'($urandom));
      junk(S_IDLE, 1'b0, 1'($urandom), 1'($urandom));
      return;
    end
    m_en = 1'b0;
    junk(S_JUMP, 1'b0, 1'($urandom), 1'($urandom));
  endtask
  task automatic run_instr(input int waits, input logic [2:0] op, input logic z, ov, dz,
                           input int stalls, input bit rst_save);
    logic [6:0] s;
    for (int k = 0; k < waits; k++) begin
      junk(S_FWAIT, 1'b0, 1'b0, 1'($urandom));
      if (m_en && k == MT - 1) begin
        exc_seq(2'd3, rst_save);
        return;
      end
    end
    junk(S_FOK, 1'b0, 1'b1, 1'($urandom));
    cyc(S_IDLE, 1'b0, 1'($urandom), 1'($urandom), op, z, ov, dz);
    if (op == 3'd7) begin
      if (m_en) exc_seq(2'd0, rst_save);
      return;
    end
    for (int k = 0; k < stalls; k++)
      cyc(S_IDLE, 1'b0, 1'($urandom), 1'b1, op, 1'($urandom), 1'($urandom), 1'($urandom));
    if (op == 3'd0 && (ov || dz) && m_en) begin
      cyc(S_IDLE, 1'b0, 1'($urandom), 1'b0, op, z, ov, dz);
      exc_seq(ov ? 2'd1 : 2'd2, rst_save);
      return;
    end
    case (op)
      3'd1: s = {4'b0001, z, 2'b00};
      3'd2: s = {4'b0001, !z, 2'b00};
      3'd3, 3'd4: s = 7'b0010100;
      3'd5: s = 7'b0001100;
      3'd6: s = S_RTE;
      default: s = S_IDLE;
    endcase
    cyc(s, 1'b0, 1'($urandom), 1'b0, op, z, ov, dz);
    if (op == 3'd6) m_en = 1'b1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) cyc(S_IDLE, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    cyc(S_IDLE, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_reset cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  task automatic test_seq;
    for (int i = 0; i < 4; i++) run_instr(0, 3'd0, 1'($urandom), 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_seq cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  task automatic test_branch;
    run_instr(1, 3'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(2, 3'd2, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd2, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd3, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd5, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_branch cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  task automatic test_exc;
    run_instr(0, 3'd0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    run_instr(0, 3'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_instr(0, 3'd6, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    run_instr(0, 3'd6, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_exc cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  task automatic test_timeout;
    run_instr(MT - 1, 3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(MT + 5, 3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_instr(300, 3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd6, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_timeout cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  task automatic test_stall;
    run_instr(0, 3'd4, 1'b0, 1'b0, 1'b0, 4, 1'b0);
    run_instr(1, 3'd0, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    run_instr(0, 3'd6, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_stall cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  task automatic test_invalid;
    run_instr(0, 3'd7, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd7, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    run_instr(0, 3'd6, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_instr(0, 3'd7, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_instr(0, 3'd0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_invalid cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  task automatic test_random;
    for (int n = 0; n < 120; n++)
      run_instr($urandom_range(9, 0) == 0 ? MT + 1 : int'($urandom_range(3, 0)), 3'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(2, 0)),
                $urandom_range(19, 0) == 0);
    for (int i = 0; q_exp.size() > 0; i++) begin
      n_run++;
      if (q_obs[0] !== q_exp[0]) begin n_fail++; $display("FAIL test_random cyc %0d: got %b want %b", i, q_obs[0], q_exp[0]); end
      void'(q_obs.pop_front()); void'(q_exp.pop_front());
    end
  endtask
  initial begin
    test_reset;
    test_seq;
    test_branch;
    test_exc;
    test_timeout;
    test_stall;
    test_invalid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Multicycle sequencer for the PC update path. It owns the 2-bit selector of the 4:1 PC source mux and the PC write enable.
- Mux inputs: 0 = ALU result (PC+4), 1 = ALUOut (branch target / JR register), 2 = jump target, 3 = exception vector / EPC.
- It steps the fetch / decode / execute cycle, qualifies branches on the ALU zero flag, times out stalled fetches, and runs the two-cycle exception entry and the RTE return.

Parameters:
MEM_TIMEOUT, 15, number of fetch-wait cycles without mem_ready before a bus-timeout exception (range 2..255).
TW, 8, fetch timer width; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
op_kind  in  3  decoded instruction class, valid from DECODE on: 0 ALU, 1 BEQ, 2 BNE, 3 J, 4 JAL, 5 JR, 6 RTE, 7 INVALID.
alu_zero  in  1  ALU zero flag, sampled in EXEC.
exc_ovf  in  1  arithmetic overflow, sampled in EXEC.
exc_div0  in  1  divide by zero, sampled in EXEC.
stall  in  1  holds EXEC; used by multicycle mult/div.
mem_ready  in  1  instruction memory data valid.
mem_rd  out  1  instruction fetch request.
ir_write  out  1  instruction register load.
pc_sel  out  2  PC mux selector.
pc_write  out  1  PC register load.
epc_write  out  1  EPC load.
vec_epc  out  1  1 = mux input 3 carries EPC; 0 = vector table.
exc_code  out  2  registered cause: 0 invalid opcode, 1 overflow, 2 div0, 3 bus timeout.
exc_en  out  1  exceptions enabled.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: state RESET_S, timer 0, exc_code 0, exc_en 1. All combinational outputs are 0 in RESET_S.
- Reset held mid-operation aborts the current state immediately with no partial writes. The first cycle after reset deasserts is RESET_S; the next state is FETCH.
- Outputs are decoded from the registered state plus the current inputs. pc_sel is 0 in every state unless stated below.
- FETCH:
  - mem_rd = 1.
  - If mem_ready: ir_write = 1, pc_write = 1, pc_sel = 0, timer cleared, go to DECODE.
  - Else the timer increments, saturating at all ones.
  - If timer == MEM_TIMEOUT-1, mem_ready = 0 and exc_en = 1: go to EXC_SAVE with cause 3.
  - If exc_en = 0, keep waiting.
  - Minimum instruction length is 3 cycles: FETCH, DECODE, EXEC.
- DECODE: lasts one cycle.
  - op_kind = 7 with exc_en = 1: go to EXC_SAVE, cause 0.
  - op_kind = 7 with exc_en = 0: treat as NOP, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - stall = 1: stay in EXEC with every write strobe 0. Exception inputs are ignored while stalled.
  - Otherwise, if op_kind = 0 and (exc_ovf or exc_div0) and exc_en = 1: go to EXC_SAVE. Overflow takes priority over div0.
  - Exception priority beats any commit; no PC write happens in that cycle.
  - Otherwise commit, then go to FETCH:
    - BEQ: pc_sel 1, pc_write = alu_zero.
    - BNE: pc_sel 1, pc_write = !alu_zero.
    - J / JAL: pc_sel 2, pc_write 1.
    - JR: pc_sel 1, pc_write 1.
    - RTE: pc_sel 3, vec_epc 1, pc_write 1, exc_en set to 1.
    - ALU: no PC write.
- EXC_SAVE: epc_write = 1 (the PC already holds PC+4). exc_code is latched on entry. exc_en cleared to 0. Go to EXC_JUMP.
- EXC_JUMP: pc_sel 3, vec_epc 0, pc_write 1. Go to FETCH.
- Exceptions while exc_en = 0 are ignored; there is no nesting.
- Invariant: pc_write and epc_write are never asserted in the same cycle.

Decomposition:
- Shared package / include pc_ctrl_pkg holds:
  - the state encodings RESET_S, FETCH, DECODE, EXEC, EXC_SAVE, EXC_JUMP;
  - the op_kind codes;
  - the exc_code values;
  - the pc_sel constants PCSEL_SEQ = 0, PCSEL_ALUOUT = 1, PCSEL_JUMP = 2, PCSEL_EXC = 3.
- One sub-module, pc_ctrl_timer: saturating fetch-wait counter with clear and a terminal-count flag.

Test Plan:
- Reset held 3 cycles, then mem_ready = 1 at all times → FETCH on cycle 2 after release; pc_write and ir_write pulse once every 3 cycles with pc_sel 0.
- BEQ with alu_zero = 1, then BEQ with alu_zero = 0, then BNE with alu_zero = 0 → EXEC pc_write = 1/0/1, with pc_sel = 1 each time.
- ALU op with exc_ovf = 1 and exc_div0 = 1 → exc_code 1; epc_write in EXC_SAVE; pc_write with pc_sel 3 and vec_epc 0 in EXC_JUMP; exc_en 0. A second overflow is then ignored. RTE → pc_sel 3, vec_epc 1, exc_en back to 1.
- mem_ready held 0 with MEM_TIMEOUT = 15 → EXC_SAVE entered after exactly 15 FETCH cycles with exc_code 3. Same stimulus with exc_en = 0 → FETCH held indefinitely, timer saturates.
- JAL with stall = 1 for 4 cycles → EXEC held 5 cycles with no strobes; pc_write with pc_sel 2 only in the 5th cycle.
- op_kind 7 → exc_code 0 raised from DECODE. Reset asserted in EXC_SAVE → no pc_write; state RESET_S with exc_en = 1.
